io_serial_tx: RTL and testbench



---
 rtl/io_serial_tx.sv | 204 ++++++++++++++++++++
 tb/tb_io_serial_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_serial_tx.sv
// Memory-mapped serial transmitter: toggle-triggered 4-entry byte FIFO feeding an async 8N1 framer.
// Define IO_TX_PARITY_EN to add an even-parity bit (8E1 frame) and advertise it in in_port0[6].
module io_serial_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic [31:0] out_port0,
    input  logic [31:0] out_port1,
    output logic [31:0] in_port0,
    output logic        tx
);

    localparam int FIFO_DEPTH = 4;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef IO_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t              state_r, next_state_s;
    logic [BAUD_W-1:0]   baud_r, baud_next_s;
    logic [2:0]          bit_r, bit_next_s;
    logic [7:0]          data_r, data_next_s;
    logic                tx_r, tx_next_s;
    logic [7:0]          fifo_r [FIFO_DEPTH];
    logic [1:0]          wr_ptr_r, rd_ptr_r;
    logic [2:0]          count_r, count_next_s;
    logic                tog_r;
    logic                overflow_r, overflow_next_s;
    logic [7:0]          frames_r;
    logic [31:0]         status_r;
    logic                req_s, push_s, pop_s, full_s, busy_s, baud_end_s, frame_done_s;
    logic                unused_bits_s;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    assign unused_bits_s = ^{out_port0[31:8], out_port1[31:2]};
    assign full_s        = (count_r == 3'(FIFO_DEPTH));
    assign req_s         = out_port1[0] ^ tog_r;
    // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
    assign push_s        = req_s & (~full_s | pop_s);
    assign baud_end_s    = (baud_r == BAUD_LAST);
    assign busy_s        = (state_r != ST_IDLE) | (count_r != 3'd0);

    // Frame sequencer: next state, baud/bit counters, FIFO pop and registered tx value.
    always_comb begin
        next_state_s = state_r;
        baud_next_s  = baud_r + {{(BAUD_W-1){1'b0}}, 1'b1};
        bit_next_s   = bit_r;
        pop_s        = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_next_s = '0;
                if (count_r != 3'd0) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_next_s  = '0;
                    bit_next_s   = 3'd0;
                    next_state_s = ST_DATA;
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_next_s = '0;
                    if (bit_r == 3'd7) begin
                        next_state_s = PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_next_s = bit_r + 3'd1;
                    end
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (baud_end_s) begin
                    baud_next_s  = '0;
                    next_state_s = ST_STOP;
                end else begin
                    next_state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_next_s  = '0;
                    frame_done_s = 1'b1;
                    if (count_r != 3'd0) begin
                        pop_s        = 1'b1;
                        next_state_s = ST_START;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            default: begin
                baud_next_s  = '0;
                next_state_s = ST_IDLE;
            end
        endcase

        if (pop_s) begin
            data_next_s = fifo_r[rd_ptr_r];
        end else begin
            data_next_s = data_r;
        end

        case (next_state_s)
            ST_IDLE:   tx_next_s = 1'b1;
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = data_r[bit_next_s];
            ST_PARITY: tx_next_s = even_parity(data_r);
            ST_STOP:   tx_next_s = 1'b1;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // FIFO occupancy and sticky overflow; a set wins over a same-edge clear.
    always_comb begin
        count_next_s    = count_r;
        overflow_next_s = overflow_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + 3'd1;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - 3'd1;
        end else begin
            count_next_s = count_r;
        end
        if (req_s && full_s && !pop_s) begin
            overflow_next_s = 1'b1;
        end else if (out_port1[1]) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // Sequencer, FIFO storage and status registers.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_r    <= ST_IDLE;
            baud_r     <= '0;
            bit_r      <= 3'd0;
            data_r     <= 8'd0;
            tx_r       <= 1'b1;
            wr_ptr_r   <= 2'd0;
            rd_ptr_r   <= 2'd0;
            count_r    <= 3'd0;
            tog_r      <= 1'b0;
            overflow_r <= 1'b0;
            frames_r   <= 8'd0;
            status_r   <= 32'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_r[i] <= 8'd0;
            end
        end else begin
            state_r    <= next_state_s;
            baud_r     <= baud_next_s;
            bit_r      <= bit_next_s;
            data_r     <= data_next_s;
            tx_r       <= tx_next_s;
            count_r    <= count_next_s;
            tog_r      <= out_port1[0];
            overflow_r <= overflow_next_s;
            if (push_s) begin
                fifo_r[wr_ptr_r] <= out_port0[7:0];
                wr_ptr_r         <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            if (frame_done_s) begin
                frames_r <= frames_r + 8'd1;
            end
            status_r <= {16'd0, frames_r, 1'b0, PARITY_EN, overflow_r, count_r, full_s, busy_s};
        end
    end

    assign in_port0 = status_r;
    assign tx       = tx_r;

endmodule

// File: tb/tb_io_serial_tx.sv
// Scoreboard bench for io_serial_tx: a transaction-level model predicts popped bytes and status,
// a tx decoder reconstructs frames and compares them against the expected queue.
module tb_io_serial_tx;

    localparam int CPB = 4;
`ifdef IO_TX_PARITY_EN
    localparam int   NBITS = 11;
    localparam logic PAR   = 1'b1;
`else
    localparam int   NBITS = 10;
    localparam logic PAR   = 1'b0;
`endif
    localparam int FL = NBITS * CPB;

    logic        clock = 1'b0;
    logic        clrn;
    logic [31:0] out_port0, out_port1, in_port0;
    logic        tx;

    always #5 clock = ~clock;

    io_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .clrn(clrn), .out_port0(out_port0),
        .out_port1(out_port1), .in_port0(in_port0), .tx(tx)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0]  b;
        logic [31:0] cyc;
    } exp_t;

    logic [7:0]  mq[$];
    exp_t        sb[$];
    int unsigned cyc = 0;
    bit          m_active = 1'b0;
    int unsigned m_end = 0;
    logic [7:0]  m_frames = 8'd0;
    bit          m_ovf = 1'b0;
    bit          m_tog = 1'b0;
    bit          m_req, m_pop, m_ovf_set;
    logic [31:0] exp_status = 32'd0;
    exp_t        m_e;

    function automatic logic [31:0] model_status();
        logic busy;
        busy = m_active || (mq.size() != 0);
        return {16'd0, m_frames, 1'b0, PAR, m_ovf, 3'(mq.size()), (mq.size() == 4), busy};
    endfunction

    initial forever begin
        @(posedge clock);
        cyc++;
        if (!clrn) begin
            mq.delete();
            sb.delete();
            m_active = 1'b0;
            m_frames = 8'd0;
            m_ovf = 1'b0;
            m_tog = 1'b0;
            exp_status = 32'd0;
        end else begin
            exp_status = model_status();
            m_req = (out_port1[0] != m_tog);
            m_tog = out_port1[0];
            m_pop = (mq.size() != 0) && (!m_active || cyc == m_end);
            if (m_active && cyc == m_end) begin
                m_frames++;
                m_active = 1'b0;
            end
            if (m_pop) begin
                m_e.b   = mq.pop_front();
                m_e.cyc = cyc;
                sb.push_back(m_e);
                m_active = 1'b1;
                m_end = cyc + FL;
            end
            m_ovf_set = 1'b0;
            if (m_req) begin
                if (mq.size() < 4) mq.push_back(out_port0[7:0]);
                else m_ovf_set = 1'b1;
            end
            if (m_ovf_set) m_ovf = 1'b1;
            else if (out_port1[1]) m_ovf = 1'b0;
        end
    end

    // ---------------- status checker ----------------
    initial forever begin
        @(negedge clock);
        if (!clrn) begin
            check("reset_status", in_port0, 32'd0);
            check("reset_tx", {31'd0, tx}, 32'd1);
        end else begin
            check("status", in_port0, exp_status);
        end
    end

    // ---------------- tx frame monitor ----------------
    bit               in_frame = 1'b0;
    int               k;
    logic [NBITS-1:0] bits;
    bit               glitch;
    logic [31:0]      start_c;
    logic [7:0]       last_rx = 8'd0;
    exp_t             mon_e;

    initial forever begin
        @(negedge clock);
        if (!clrn) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx == 1'b0) begin
                in_frame = 1'b1;
                bits     = '0;
                glitch   = 1'b0;
                k        = 1;
                start_c  = cyc;
            end
        end else begin
            if (k % CPB == 0) bits[k / CPB] = tx;
            else if (tx !== bits[k / CPB]) glitch = 1'b1;
            k++;
            if (k == FL) begin
                in_frame = 1'b0;
                last_rx  = bits[8:1];
                check("bit_stable", {31'd0, glitch}, 32'd0);
                check("stop_bit", {31'd0, bits[NBITS-1]}, 32'd1);
`ifdef IO_TX_PARITY_EN
                check("parity_bit", {31'd0, bits[9]}, {31'd0, ^bits[8:1]});
`endif
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", bits[8:1]);
                end else begin
                    mon_e = sb.pop_front();
                    check("frame_byte", {24'd0, bits[8:1]}, {24'd0, mon_e.b});
                    check("frame_start_cycle", start_c, mon_e.cyc);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic toggle(input logic [7:0] b);
        @(negedge clock);
        #1;
        out_port0    = ($urandom() & 32'hFFFF_FF00) | {24'd0, b};
        out_port1[0] = ~out_port1[0];
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((m_active || mq.size() != 0) && n < budget);
        tests++;
        if (m_active || mq.size() != 0) begin
            fails++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
        end
        repeat (3) @(negedge clock);
    endtask

    int          n;
    logic [31:0] c0;
    logic [7:0]  fbase;

    initial begin
        clrn      = 1'b0;
        out_port0 = $urandom();
        out_port1 = $urandom();
        repeat (5) @(negedge clock);
        #1;
        out_port0 = 32'd0;
        out_port1 = 32'd0;
        @(negedge clock);
        #1 clrn = 1'b1;
        repeat (100) @(negedge clock);
        check("idle_tx", {31'd0, tx}, 32'd1);

        // single byte
        toggle(8'h5A);
        wait_idle(2 * FL);
        check("single_frames", {24'd0, in_port0[15:8]}, 32'd1);
        check("single_busy", {31'd0, in_port0[0]}, 32'd0);
        check("single_byte", {24'd0, last_rx}, 32'h5A);

        // back-to-back
        fbase = in_port0[15:8];
        for (int i = 1; i <= 4; i++) toggle(8'(i));
        repeat (2) @(negedge clock);
        check("b2b_peak_count", {29'd0, in_port0[4:2]}, 32'd3);
        wait_idle(6 * FL);
        check("b2b_frames", {24'd0, in_port0[15:8]}, {24'd0, fbase + 8'd4});

        // overflow
        fbase = in_port0[15:8];
        for (int i = 0; i < 6; i++) toggle(8'h10 + 8'(i));
        repeat (2) @(negedge clock);
        check("ovf_set", {31'd0, in_port0[5]}, 32'd1);
        check("ovf_count", {29'd0, in_port0[4:2]}, 32'd4);
        @(negedge clock);
        #1 out_port1[1] = 1'b1;
        @(negedge clock);
        #1 out_port1[1] = 1'b0;
        repeat (2) @(negedge clock);
        check("ovf_clear", {31'd0, in_port0[5]}, 32'd0);
        wait_idle(7 * FL);
        check("ovf_frames", {24'd0, in_port0[15:8]}, {24'd0, fbase + 8'd5});

        // full FIFO with a push on the STOP-exit edge
        for (int i = 0; i < 5; i++) toggle(8'hA0 + 8'(i));
        n = 0;
        while (cyc != m_end - 1 && n < 2 * FL) begin
            @(negedge clock);
            n++;
        end
        #1;
        out_port0    = 32'h0000_00C3;
        out_port1[0] = ~out_port1[0];
        repeat (2) @(negedge clock);
        check("fullpop_count", {29'd0, in_port0[4:2]}, 32'd4);
        check("fullpop_ovf", {31'd0, in_port0[5]}, 32'd0);
        wait_idle(7 * FL);

        // reset during data bit 3
        toggle(8'h3C);
        toggle(8'h77);
        n = 0;
        while (sb.size() == 0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        c0 = sb[$].cyc;
        n = 0;
        while (cyc != c0 + 4 * CPB + 1 && n < 2 * FL) begin
            @(negedge clock);
            n++;
        end
        #1 clrn = 1'b0;
        #1 check("midframe_tx", {31'd0, tx}, 32'd1);
        out_port1 = 32'd0;
        repeat (3) @(negedge clock);
        #1 clrn = 1'b1;
        repeat (2) @(negedge clock);
        check("after_reset_status", in_port0, {25'd0, PAR, 6'd0});
        repeat (3 * FL) @(negedge clock);
        check("after_reset_tx", {31'd0, tx}, 32'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            #1;
            out_port0    = $urandom();
            out_port1[1] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0) out_port1[0] = ~out_port1[0];
        end
        @(negedge clock);
        #1 out_port1[1] = 1'b0;
        wait_idle(8 * FL);

        check("sb_empty", sb.size(), 32'd0);
        check("monitor_idle", {31'd0, in_frame}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
